// File: rtl/pet_scan_doubler.sv
// pet_scan_doubler: line doubler from the 15.6 kHz PET raster to a 31.25 kHz VGA raster
// Ports: clk16_i/reset_i (sync, active high); pixel_en_i, video_i, h_sync_i, v_sync_i (active-low syncs)
//        from the video stage; vga_video_o, vga_h_sync_o, vga_v_sync_o (registered, active-low syncs)
//        and locked_o to the monitor side.
// Option: PET_SCAN_DOUBLER_SCANLINES_EN adds scanlines_i, which blanks the second replay of each line.
module pet_scan_doubler #(
   parameter int LINE_PIXELS  = 320,
   parameter int ADDR_W       = 9,
   parameter int CNT_W        = 11,
   parameter int HSYNC_CLKS   = 61,
   parameter int OUT_START    = 112,
   parameter int DEFAULT_HALF = 512,
   parameter int MIN_PERIOD   = 640
) (
   input  logic clk16_i,
   input  logic reset_i,
   input  logic pixel_en_i,
   input  logic video_i,
   input  logic h_sync_i,
   input  logic v_sync_i,
`ifdef PET_SCAN_DOUBLER_SCANLINES_EN
   input  logic scanlines_i,
`endif
   output logic vga_video_o,
   output logic vga_h_sync_o,
   output logic vga_v_sync_o,
   output logic locked_o
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   typedef enum logic {PH_A, PH_B} ph_t;
   logic mem [2**(ADDR_W+1)];
   logic h1_q, h2_q, ls;
   logic bank_q, wr_bank, wr_en;
   logic [ADDR_W:0] wr_x_q, wr_x_d, wr_x_eff, len_q;
   logic [CNT_W-1:0] per_q, per_d, period, half_q, half_d, prev_q, prev_d, oc_q, oc_d, rel;
   logic prev_ok_q, prev_ok_d, locked_q, locked_d, sat, valid, close;
   ph_t ph_q, ph_d;
   logic in_win, blank, hs_d, vid_q, hs_q, vs_q;
   assign ls = h2_q & ~h1_q;
   // capture and line-period measurement; period counts the LS clock itself
   always_comb begin
      sat      = per_q == CNT_MAX;
      period   = sat ? per_q : per_q + 1'b1;
      valid    = !sat && period >= CNT_W'(MIN_PERIOD);
      close    = period == prev_q || period == prev_q + 1'b1 || prev_q == period + 1'b1;
      per_d    = ls ? '0 : period;
      wr_bank  = ls ? ~bank_q : bank_q;
      wr_x_eff = ls ? '0 : wr_x_q;
      wr_en    = pixel_en_i && wr_x_eff < (ADDR_W+1)'(LINE_PIXELS);
      wr_x_d   = wr_x_eff + (ADDR_W+1)'(wr_en);
      locked_d  = ls ? valid && prev_ok_q && close : (sat ? 1'b0 : locked_q);
      half_d    = (ls && valid) ? period >> 1 : ((ls || sat) ? CNT_W'(DEFAULT_HALF) : half_q);
      prev_d    = ls ? period : prev_q;
      prev_ok_d = ls ? valid : (sat ? 1'b0 : prev_ok_q);
   end
   // output sequencer: state register
   always_ff @(posedge clk16_i) begin
      if (reset_i) begin
         ph_q <= PH_A;
         oc_q <= '0;
      end else begin
         ph_q <= ph_d;
         oc_q <= oc_d;
      end
   end
   // output sequencer: next state; >= guards against half_period shrinking mid-phase
   always_comb begin
      ph_d = ph_q;
      oc_d = oc_q + 1'b1;
      if (ls) begin
         ph_d = PH_A;
         oc_d = '0;
      end else if (ph_q == PH_A && oc_q >= half_q - 1'b1) begin
         ph_d = PH_B;
         oc_d = '0;
      end else if (ph_q == PH_B && oc_q == CNT_MAX) begin
         ph_d = PH_A;
         oc_d = '0;
      end
   end
   // output sequencer: outputs
   always_comb begin
      rel    = oc_q - CNT_W'(OUT_START);
      in_win = oc_q >= CNT_W'(OUT_START) && rel < CNT_W'(len_q);
      hs_d   = oc_q >= CNT_W'(HSYNC_CLKS);
`ifdef PET_SCAN_DOUBLER_SCANLINES_EN
      blank  = !locked_q || !in_win || (scanlines_i && ph_q == PH_B);
`else
      blank  = !locked_q || !in_win;
`endif
   end
   always_ff @(posedge clk16_i) begin
      if (!reset_i && wr_en)
         mem[{wr_bank, wr_x_eff[ADDR_W-1:0]}] <= video_i;
   end
   // reads use ~wr_bank so even the LS clock never touches the bank being written
   always_ff @(posedge clk16_i) begin
      if (reset_i) begin
         h1_q      <= 1'b1;
         h2_q      <= 1'b1;
         bank_q    <= 1'b0;
         wr_x_q    <= '0;
         len_q     <= '0;
         per_q     <= '0;
         half_q    <= CNT_W'(DEFAULT_HALF);
         prev_q    <= '0;
         prev_ok_q <= 1'b0;
         locked_q  <= 1'b0;
         vid_q     <= 1'b0;
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
      end else begin
         h1_q      <= h_sync_i;
         h2_q      <= h1_q;
         bank_q    <= wr_bank;
         wr_x_q    <= wr_x_d;
         len_q     <= ls ? wr_x_q : len_q;
         per_q     <= per_d;
         half_q    <= half_d;
         prev_q    <= prev_d;
         prev_ok_q <= prev_ok_d;
         locked_q  <= locked_d;
         vid_q     <= !blank && mem[{~wr_bank, rel[ADDR_W-1:0]}];
         hs_q      <= hs_d;
         vs_q      <= oc_q == '0 ? v_sync_i : vs_q;
      end
   end
   assign vga_video_o  = vid_q;
   assign vga_h_sync_o = hs_q;
   assign vga_v_sync_o = vs_q;
   assign locked_o     = locked_q;
endmodule

// File: tb/tb_pet_scan_doubler.sv
// tb_pet_scan_doubler: randomized line stimulus with a queue-based scoreboard for pet_scan_doubler
module tb_pet_scan_doubler;
   logic clk = 0, rst = 1, pe = 0, vid = 0, hs = 1, vs = 1;
   logic vv, vh, vvs, lk;
   bit scan = 0;
   always #5 clk = ~clk;
   pet_scan_doubler dut (
      .clk16_i(clk), .reset_i(rst), .pixel_en_i(pe), .video_i(vid), .h_sync_i(hs), .v_sync_i(vs),
`ifdef PET_SCAN_DOUBLER_SCANLINES_EN
      .scanlines_i(scan),
`endif
      .vga_video_o(vv), .vga_h_sync_o(vh), .vga_v_sync_o(vvs), .locked_o(lk)
   );
   typedef struct packed {
      logic [319:0] pix;
      int len;
      int n;
      logic lk;
      logic v;
      logic sb;
   } exp_t;
   exp_t q[$];
   int checks = 0, errors = 0;
   bit active = 1;
   int prev_p = 0, pv = 0, prev_n = 0;
   bit pok = 0;
   logic [319:0] prev_pix = '0;
   task automatic chk(string nm, int act, int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, expv);
      end
   endtask
   // one input line of per clocks; the replay during this line shows the previous line twice
   task automatic run_line(int per, int np, logic [399:0] bits, bit v, bit push);
      int p, half;
      bit ok, lkx;
      exp_t e;
      p = prev_p;
      ok = p >= 640 && p <= 2047;
      if (ok) begin
         half = p / 2;
         lkx = pok && p - pv <= 1 && pv - p <= 1;
         pv = p;
      end else begin
         half = 512;
         lkx = 0;
      end
      pok = ok;
      if (push) begin
         e.pix = prev_pix; e.n = prev_n; e.lk = lkx; e.v = v;
         e.len = half; e.sb = 0;
         q.push_back(e);
         e.len = per - half; e.sb = scan;
         q.push_back(e);
      end
      prev_p = per;
      prev_pix = bits[319:0];
      prev_n = np > 320 ? 320 : np;
      vs = v;
      for (int c = 0; c < per; c++) begin
         hs = c >= 64;
         pe = 0;
         if (c >= 100 && (c - 100) % 2 == 0 && (c - 100) / 2 < np) begin
            pe = 1;
            vid = bits[(c - 100) / 2];
         end
         @(posedge clk); #1;
      end
      pe = 0;
   endtask
   // monitor: each output hsync fall starts a half-line that is scored against the queue head
   initial begin
      exp_t e;
      bit busy = 0, ph = 1, fell;
      int k = 0, hsw = 0, bad = 0;
      logic xb;
      forever begin
         @(negedge clk);
         fell = ph && !vh;
         ph = vh;
         if (busy && (fell || !active || k > e.len + 8)) begin
            busy = 0;
            if (active) begin
               chk("half_len", fell ? k : -1, e.len);
               chk("hsync_width", hsw, 61);
               chk("video_bits_wrong", bad, 0);
            end
         end
         if (fell && active && q.size() > 0) begin
            e = q.pop_front();
            busy = 1; k = 0; hsw = 0; bad = 0;
            chk("locked", int'(lk), int'(e.lk));
            chk("vsync", int'(vvs), int'(e.v));
         end
         if (busy) begin
            xb = (e.lk && !e.sb && k >= 112 && k < 112 + e.n) ? e.pix[k - 112] : 1'b0;
            if (vv !== xb) bad++;
            if (!vh) hsw++;
            k++;
         end
      end
   end
   initial begin
      logic [399:0] alt, rnd, ones;
      int first_zero, f1, f2, n_ones;
      bit hp;
`ifdef PET_SCAN_DOUBLER_SCANLINES_EN
      scan = 1;
`endif
      for (int i = 0; i < 400; i++) begin
         alt[i] = ~i[0];
         ones[i] = 1'b1;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_hsync", int'(vh), 1);
      chk("rst_vsync", int'(vvs), 1);
      chk("rst_video", int'(vv), 0);
      chk("rst_locked", int'(lk), 0);
      rst = 0;
      repeat (100) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) run_line(1024, 320, alt, 1'($urandom_range(0, 1)), 1);
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 400; j++) rnd[j] = 1'($urandom);
         run_line(i % 2 ? 1025 : 1023, $urandom_range(0, 400), rnd, 1'($urandom_range(0, 1)), 1);
      end
      run_line(1024, 320, ones, 1, 1);
      run_line(1025, 0, ones, 0, 1);
      run_line(1024, 400, alt, 1, 1);
      run_line(1025, 320, ones, 1, 1);
      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < 400; j++) rnd[j] = 1'($urandom);
         run_line($urandom_range(1023, 1025), $urandom_range(0, 400), rnd, 1'($urandom_range(0, 1)), 1);
      end
      run_line(1024, 320, alt, 1, 1);
      run_line(1024, 320, alt, 1, 1);
      // final line start, then h_sync_i stops toggling
      first_zero = 0; f1 = -1; f2 = -1; n_ones = 0; hp = 1;
      hs = 0;
      for (int n = 1; n <= 4200; n++) begin
         @(posedge clk); #1;
         if (n == 64) hs = 1;
         if (n == 2049) chk("lock_hold", int'(lk), 1);
         if (!lk && first_zero == 0) first_zero = n;
         if (first_zero > 0) begin
            if (vv) n_ones++;
            if (hp && !vh) begin
               if (f1 < 0) f1 = n;
               else if (f2 < 0) f2 = n;
            end
         end
         hp = vh;
      end
      chk("lock_drop_clk", first_zero, 2050);
      chk("freerun_half", f2 - f1, 512);
      chk("freerun_video", n_ones, 0);
      prev_p = 99999;
      for (int i = 0; i < 3; i++) run_line(1024, 320, alt, 1'($urandom_range(0, 1)), 1);
      run_line(300, 0, alt, 1, 1);
      active = 0;
      q.delete();
      rst = 1;
      @(posedge clk); #1;
      chk("midrst_hsync", int'(vh), 1);
      chk("midrst_vsync", int'(vvs), 1);
      chk("midrst_video", int'(vv), 0);
      chk("midrst_locked", int'(lk), 0);
      rst = 0;
      repeat (5) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
